// File: rtl/updown_counter_n.sv
// updown_counter_n: modulo-(MAX_VAL+1) up/down counter with synchronous load,
// combinational terminal-count flag and a registered one-cycle wrap pulse.
// Optional macro UPDOWN_COUNTER_SAT_EN adds a 'sat' input; when sat=1 the
// counter clamps at its end points instead of wrapping.
module updown_counter_n #(
    parameter int              WIDTH   = 8,
    parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef UPDOWN_COUNTER_SAT_EN
    input  logic             sat,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam longint unsigned FULL_RANGE = (64'd1 << WIDTH) - 64'd1;
    localparam logic [WIDTH-1:0] MAX = MAX_VAL[WIDTH-1:0];

    // Reject illegal configurations while elaborating, not in silicon.
    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("updown_counter_n: WIDTH must be within 2..32");
        end
        if (MAX_VAL < 64'd1 || MAX_VAL > FULL_RANGE) begin : g_bad_max
            $error("updown_counter_n: MAX_VAL must be within 1..2**WIDTH-1");
        end
    endgenerate

    logic             sat_on;
    logic [WIDTH-1:0] load_clip;
    logic             at_max;
    logic             at_zero;

`ifdef UPDOWN_COUNTER_SAT_EN
    assign sat_on = sat;
`else
    assign sat_on = 1'b0;
`endif

    assign at_max  = (count == MAX);
    assign at_zero = (count == '0);

    // Loaded values above the terminal count are clamped so count never leaves 0..MAX_VAL.
    always_comb begin
        load_clip = load_val;
        if (load_val > MAX)
            load_clip = MAX;
    end

    // Terminal count looks at the end point in the currently selected direction, regardless of en.
    always_comb begin
        tc = dir ? at_max : at_zero;
    end

    // Counter state: load beats en; wrap pulses for one cycle after a roll-over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                count <= load_clip;
            end else if (en) begin
                if (dir) begin
                    if (!at_max) begin
                        count <= count + 1'b1;
                    end else if (!sat_on) begin
                        count <= '0;
                        wrap  <= 1'b1;
                    end
                end else begin
                    if (!at_zero) begin
                        count <= count - 1'b1;
                    end else if (!sat_on) begin
                        count <= MAX;
                        wrap  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/updown_counter_n.md
UPDOWN_COUNTER_N -- requirements
Module: updown_counter_n

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the counter bit width; legal range 2..32.
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1, SHALL set the terminal count; the count range SHALL be 0..MAX_VAL.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous active-low reset.
REQ-005 en  input  1  SHALL enable counting when high and hold the count when low.
REQ-006 dir  input  1  SHALL select direction: 1 = up, 0 = down.
REQ-007 load  input  1  SHALL be the synchronous load strobe.
REQ-008 load_val  input  WIDTH  SHALL be the value captured on load.
REQ-009 count  output  WIDTH  SHALL be the registered counter value.
REQ-010 tc  output  1  SHALL be the combinational terminal-count flag, derived from count and dir.
REQ-011 wrap  output  1  SHALL be the registered one-cycle pulse that flags a wrap-around.

Function
REQ-012 Per-edge priority SHALL be load, then en; with neither asserted, count and wrap SHALL hold and clear respectively.
REQ-013 On load, count SHALL take min(load_val, MAX_VAL) on the next edge, irrespective of en and dir, and wrap SHALL be 0.
REQ-014 With en=1, dir=1, and count<MAX_VAL, count SHALL increment by 1 with latency of one clock.
REQ-015 With en=1, dir=0, and count>0, count SHALL decrement by 1.
REQ-016 With en=1, dir=1, and count==MAX_VAL, count SHALL become 0 and wrap SHALL be 1 for exactly the following cycle (wrap mode).
REQ-017 With en=1, dir=0, and count==0, count SHALL become MAX_VAL and wrap SHALL be 1 for the following cycle (wrap mode).
REQ-018 tc SHALL be 1 when (dir=1 and count==MAX_VAL) or (dir=0 and count==0), and SHALL be 0 otherwise, independent of en.
REQ-019 A dir change SHALL take effect on the same edge on which it is sampled, with no idle cycle.
REQ-020 wrap SHALL be 0 in every cycle not immediately following a wrap event.
REQ-021 Arithmetic SHALL be modulo MAX_VAL+1; count SHALL never exceed MAX_VAL.
REQ-022 MAX_VAL outside 1..2**WIDTH-1 SHALL cause an elaboration-time error.

Reset
REQ-023 On rst_n=0, count SHALL be 0 and wrap SHALL be 0 immediately, without waiting for clk.
REQ-024 With count=0 held in reset, tc SHALL follow REQ-018: it is 1 when dir=0 and 0 when dir=1.
REQ-025 Reset asserted mid-count SHALL discard any pending load or increment; on the first rising edge after rst_n deasserts, normal REQ-012 behaviour SHALL resume.
REQ-026 No internal state SHALL survive reset.

Configuration
REQ-027 Macro UPDOWN_COUNTER_SAT_EN SHALL compile in an extra port, sat  input  1, which selects saturating mode.
REQ-028 With the macro defined and sat=1, count SHALL hold at MAX_VAL (up) or 0 (down) instead of wrapping, wrap SHALL stay 0, and tc SHALL behave as in REQ-018.
REQ-029 With the macro defined and sat=0, and with the macro undefined (sat port absent), the block SHALL wrap per REQ-016/REQ-017.

Verification
REQ-030 Reset: WIDTH=4, MAX_VAL=9; hold rst_n=0 and assert it asynchronously between edges -> count=0 and wrap=0 immediately, tc=1 with dir=0.
REQ-031 Decade up-wrap: WIDTH=4, MAX_VAL=9, en=1, dir=1 from 0 for 11 edges -> count 1..9,0,1; tc=1 while count=9; wrap=1 only in the cycle count=0.
REQ-032 Down-wrap with direction switch: from count=2, dir=0 for 3 edges -> count 1,0,9 with wrap pulse; then dir=1 -> count 0 on the next edge.
REQ-033 Load: load=1, load_val=4'd13, MAX_VAL=9 -> count=9; load=1 together with en=1, dir=1, load_val=3 -> count=3 (load wins).
REQ-034 Saturation (macro defined): sat=1, dir=1 at count=9 for 3 edges -> count stays 9 and wrap=0; dir=0 at count=0 -> count stays 0.
REQ-035 Enable hold and reset mid-run: en=0 for 5 edges at count=6 -> count stays 6; then rst_n=0 mid-cycle -> count=0 at once, and counting resumes from 0 after release.
